// File: rtl/rf_access_sequencer.sv
// Operand-read / writeback sequencer in front of a handshaked register file.
// Optional build macro RF_BYPASS_EN: forward a pending writeback to a hazarding read instead of stalling.
module rf_access_sequencer #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 5,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [ADDR_W-1:0] i_rs1_addr,
   input  logic [ADDR_W-1:0] i_rs2_addr,
   output logic              o_op_valid,
   output logic [DATA_W-1:0] o_rs1_data,
   output logic [DATA_W-1:0] o_rs2_data,
   input  logic              i_wb_valid,
   input  logic [ADDR_W-1:0] i_wb_addr,
   input  logic [DATA_W-1:0] i_wb_data,
   output logic              o_wb_ready,
   output logic              o_rf_rd_en,
   output logic [ADDR_W-1:0] o_rf_reg_addr,
   input  logic [DATA_W-1:0] i_rf_reg_data,
   input  logic              i_rf_rd_valid,
   output logic              o_rf_wr_en,
   output logic [ADDR_W-1:0] o_rf_dest_addr,
   output logic [DATA_W-1:0] o_rf_dest_data,
   input  logic              i_rf_wr_valid,
   output logic              o_timeout
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

   typedef enum logic [1:0] {IDLE = 2'd0, RS1 = 2'd1, RS2 = 2'd2, DONE = 2'd3} rd_state_e;
   typedef enum logic {W_IDLE = 1'b0, W_BUSY = 1'b1} wr_state_e;

   rd_state_e         rd_state_q, rd_state_d;
   logic [ADDR_W-1:0] rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d;
   logic [DATA_W-1:0] op1_q, op1_d;
   logic [DATA_W-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;

   wr_state_e         wr_state_q, wr_state_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              wr_en_q, wr_en_d;
   logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

   logic              timeout_q;
   logic              rd_to_s, wr_to_s;
   logic              wr_busy_s, wb_take_s;
   logic [ADDR_W-1:0] cur_addr_s;
   logic              op_done_s;
   logic [DATA_W-1:0] op_val_s;

   // A read must not overtake a writeback to the same register that is in flight or arriving now.
   function automatic logic hazard_f(
      input logic [ADDR_W-1:0] op_addr,
      input logic              wr_busy,
      input logic [ADDR_W-1:0] busy_addr,
      input logic              wb_take,
      input logic [ADDR_W-1:0] wb_addr
   );
      hazard_f = (wr_busy && (busy_addr == op_addr)) ||
                 (wb_take && (wb_addr != ADDR_ZERO) && (wb_addr == op_addr));
   endfunction

   assign wr_busy_s = (wr_state_q == W_BUSY);
   assign wb_take_s = i_wb_valid && !wr_busy_s;

   // Read FSM state and datapath registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_state_q <= IDLE;
         rs1_addr_q <= ADDR_ZERO;
         rs2_addr_q <= ADDR_ZERO;
         op1_q      <= DATA_ZERO;
         rs1_data_q <= DATA_ZERO;
         rs2_data_q <= DATA_ZERO;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= ADDR_ZERO;
         rd_cnt_q   <= CNT_ZERO;
      end else begin
         rd_state_q <= rd_state_d;
         rs1_addr_q <= rs1_addr_d;
         rs2_addr_q <= rs2_addr_d;
         op1_q      <= op1_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
         rd_cnt_q   <= rd_cnt_d;
      end
   end

   // Read FSM next state: fetch rs1 then rs2, each by zero-short-cut, bypass/stall, or RF read.
   always_comb begin
      rd_state_d = rd_state_q;
      rs1_addr_d = rs1_addr_q;
      rs2_addr_d = rs2_addr_q;
      op1_d      = op1_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      rd_en_d    = rd_en_q;
      rd_addr_d  = rd_addr_q;
      rd_cnt_d   = rd_cnt_q;
      rd_to_s    = 1'b0;
      op_done_s  = 1'b0;
      op_val_s   = DATA_ZERO;
      cur_addr_s = (rd_state_q == RS2) ? rs2_addr_q : rs1_addr_q;
      case (rd_state_q)
         IDLE: begin
            if (i_req_valid) begin
               rs1_addr_d = i_rs1_addr;
               rs2_addr_d = i_rs2_addr;
               rd_state_d = RS1;
            end else begin
               rd_state_d = IDLE;
            end
         end
         RS1, RS2: begin
            if (rd_en_q) begin
               // Once issued, the read finishes on RF data or timeout; hazards are no longer considered.
               if (i_rf_rd_valid) begin
                  op_done_s = 1'b1;
                  op_val_s  = i_rf_reg_data;
                  rd_en_d   = 1'b0;
               end else if ((rd_cnt_q + CNT_ONE) == CNT_LIMIT) begin
                  op_done_s = 1'b1;
                  rd_en_d   = 1'b0;
                  rd_to_s   = 1'b1;
               end else begin
                  rd_cnt_d  = rd_cnt_q + CNT_ONE;
               end
            end else if (cur_addr_s == ADDR_ZERO) begin
               op_done_s = 1'b1;
            end else if (hazard_f(cur_addr_s, wr_busy_s, wr_addr_q, wb_take_s, i_wb_addr)) begin
`ifdef RF_BYPASS_EN
               op_done_s = 1'b1;
               op_val_s  = (wr_busy_s && (wr_addr_q == cur_addr_s)) ? wr_data_q : i_wb_data;
`else
               rd_state_d = rd_state_q;
`endif
            end else begin
               rd_en_d   = 1'b1;
               rd_addr_d = cur_addr_s;
               rd_cnt_d  = CNT_ZERO;
            end
         end
         DONE: begin
            rd_state_d = IDLE;
         end
         default: begin
            rd_state_d = IDLE;
         end
      endcase
      // Outputs only change on entry to DONE so they stay stable across the next request.
      if (op_done_s) begin
         if (rd_state_q == RS1) begin
            op1_d      = op_val_s;
            rd_state_d = RS2;
         end else begin
            rs1_data_d = op1_q;
            rs2_data_d = op_val_s;
            rd_state_d = DONE;
         end
      end else begin
         op1_d = op1_q;
      end
   end

   // Write FSM state and datapath registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_state_q <= W_IDLE;
         wr_addr_q  <= ADDR_ZERO;
         wr_data_q  <= DATA_ZERO;
         wr_en_q    <= 1'b0;
         wr_cnt_q   <= CNT_ZERO;
      end else begin
         wr_state_q <= wr_state_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         wr_en_q    <= wr_en_d;
         wr_cnt_q   <= wr_cnt_d;
      end
   end

   // Write FSM next state: writes to x0 are discarded at acceptance.
   always_comb begin
      wr_state_d = wr_state_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      wr_en_d    = wr_en_q;
      wr_cnt_d   = wr_cnt_q;
      wr_to_s    = 1'b0;
      case (wr_state_q)
         W_IDLE: begin
            if (wb_take_s && (i_wb_addr != ADDR_ZERO)) begin
               wr_addr_d  = i_wb_addr;
               wr_data_d  = i_wb_data;
               wr_en_d    = 1'b1;
               wr_cnt_d   = CNT_ZERO;
               wr_state_d = W_BUSY;
            end else begin
               wr_state_d = W_IDLE;
            end
         end
         W_BUSY: begin
            if (i_rf_wr_valid) begin
               wr_en_d    = 1'b0;
               wr_state_d = W_IDLE;
            end else if ((wr_cnt_q + CNT_ONE) == CNT_LIMIT) begin
               wr_en_d    = 1'b0;
               wr_to_s    = 1'b1;
               wr_state_d = W_IDLE;
            end else begin
               wr_cnt_d   = wr_cnt_q + CNT_ONE;
            end
         end
         default: begin
            wr_en_d    = 1'b0;
            wr_state_d = W_IDLE;
         end
      endcase
   end

   // Sticky timeout flag, cleared only by reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= timeout_q | rd_to_s | wr_to_s;
      end
   end

   // Output decode from registered state.
   always_comb begin
      o_req_ready    = (rd_state_q == IDLE);
      o_op_valid     = (rd_state_q == DONE);
      o_rs1_data     = rs1_data_q;
      o_rs2_data     = rs2_data_q;
      o_rf_rd_en     = rd_en_q;
      o_rf_reg_addr  = rd_addr_q;
      o_wb_ready     = (wr_state_q == W_IDLE);
      o_rf_wr_en     = wr_en_q;
      o_rf_dest_addr = wr_addr_q;
      o_rf_dest_data = wr_data_q;
      o_timeout      = timeout_q;
   end

endmodule

// File: tb/tb_rf_access_sequencer.sv
// Directed bench for rf_access_sequencer with a behavioural register-file responder.
module tb_rf_access_sequencer;
   localparam int DW = 32;
   localparam int AW = 5;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic          i_req_valid = 1'b0;
   logic          o_req_ready;
   logic [AW-1:0] i_rs1_addr = '0;
   logic [AW-1:0] i_rs2_addr = '0;
   logic          o_op_valid;
   logic [DW-1:0] o_rs1_data, o_rs2_data;
   logic          i_wb_valid = 1'b0;
   logic [AW-1:0] i_wb_addr = '0;
   logic [DW-1:0] i_wb_data = '0;
   logic          o_wb_ready;
   logic          o_rf_rd_en;
   logic [AW-1:0] o_rf_reg_addr;
   logic [DW-1:0] i_rf_reg_data = '0;
   logic          i_rf_rd_valid = 1'b0;
   logic          o_rf_wr_en;
   logic [AW-1:0] o_rf_dest_addr;
   logic [DW-1:0] o_rf_dest_data;
   logic          i_rf_wr_valid = 1'b0;
   logic          o_timeout;

   rf_access_sequencer dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
      .o_op_valid(o_op_valid), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
      .i_wb_valid(i_wb_valid), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .o_wb_ready(o_wb_ready),
      .o_rf_rd_en(o_rf_rd_en), .o_rf_reg_addr(o_rf_reg_addr),
      .i_rf_reg_data(i_rf_reg_data), .i_rf_rd_valid(i_rf_rd_valid),
      .o_rf_wr_en(o_rf_wr_en), .o_rf_dest_addr(o_rf_dest_addr), .o_rf_dest_data(o_rf_dest_data),
      .i_rf_wr_valid(i_rf_wr_valid), .o_timeout(o_timeout)
   );

   always #5 i_clk = ~i_clk;

   logic [DW-1:0] rf_mem [0:31];
   int  rd_lat = 2;
   int  wr_lat = 3;
   bit  rd_resp_on = 1'b1;
   int  n_cmp = 0;
   int  n_bad = 0;
   int  rd_en_cycles = 0, rd_en_rises = 0, wr_en_rises = 0, op_valid_cnt = 0, overlap_cnt = 0;
   logic rd_en_prev = 1'b0, wr_en_prev = 1'b0;
   logic [DW-1:0] last_rs1 = '0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Activity monitor
   always @(negedge i_clk) begin
      if (o_rf_rd_en) rd_en_cycles <= rd_en_cycles + 1;
      if (o_rf_rd_en && !rd_en_prev) rd_en_rises <= rd_en_rises + 1;
      if (o_rf_wr_en && !wr_en_prev) wr_en_rises <= wr_en_rises + 1;
      if (o_op_valid) op_valid_cnt <= op_valid_cnt + 1;
      if (o_rf_rd_en && o_rf_wr_en) overlap_cnt <= overlap_cnt + 1;
      rd_en_prev <= o_rf_rd_en;
      wr_en_prev <= o_rf_wr_en;
   end

   // Register-file responder: valid arrives in the (lat+1)-th cycle of an enable
   initial begin
      int rc;
      int wc;
      rc = 0;
      wc = 0;
      forever begin
         @(negedge i_clk);
         if (o_rf_rd_en) begin
            if (rd_resp_on && rc == rd_lat) begin
               i_rf_rd_valid = 1'b1;
               i_rf_reg_data = rf_mem[o_rf_reg_addr];
            end else begin
               i_rf_rd_valid = 1'b0;
            end
            rc++;
         end else begin
            rc = 0;
            i_rf_rd_valid = 1'b0;
         end
         if (o_rf_wr_en) begin
            if (wc == wr_lat) begin
               i_rf_wr_valid = 1'b1;
               rf_mem[o_rf_dest_addr] = o_rf_dest_data;
            end else begin
               i_rf_wr_valid = 1'b0;
            end
            wc++;
         end else begin
            wc = 0;
            i_rf_wr_valid = 1'b0;
         end
      end
   end

   // Issue one read, wait for o_op_valid (bounded), check the one-cycle pulse and output hold.
   task automatic do_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                          output int lat, output logic [DW-1:0] d1, output logic [DW-1:0] d2);
      check_eq("req_ready_before", 64'(o_req_ready), 64'd1);
      i_rs1_addr = a1;
      i_rs2_addr = a2;
      i_req_valid = 1'b1;
      lat = -1;
      d1 = '0;
      d2 = '0;
      tick();
      i_req_valid = 1'b0;
      for (int n = 1; n <= 200; n++) begin
         if (n == 2) check_eq("rs1_hold", 64'(o_rs1_data), 64'(last_rs1));
         if (o_op_valid) begin
            lat = n;
            break;
         end
         tick();
      end
      if (lat < 0) begin
         check_eq("op_valid_wait", 64'd0, 64'd1);
      end else begin
         d1 = o_rs1_data;
         d2 = o_rs2_data;
         last_rs1 = o_rs1_data;
         tick();
         check_eq("op_valid_pulse", 64'(o_op_valid), 64'd0);
      end
   endtask

   initial begin
      int lat;
      int base;
      logic [DW-1:0] d1, d2;
      for (int i = 0; i < 32; i++) rf_mem[i] = 32'hDEAD_0000 | 32'(i);
      rf_mem[5] = 32'h0000_0011;
      rf_mem[7] = 32'h0000_0022;

      // Reset state
      tick();
      check_eq("rst_req_ready", 64'(o_req_ready), 64'd1);
      check_eq("rst_wb_ready", 64'(o_wb_ready), 64'd1);
      check_eq("rst_op_valid", 64'(o_op_valid), 64'd0);
      check_eq("rst_rd_en", 64'(o_rf_rd_en), 64'd0);
      check_eq("rst_wr_en", 64'(o_rf_wr_en), 64'd0);
      check_eq("rst_timeout", 64'(o_timeout), 64'd0);
      check_eq("rst_outputs", 64'({o_rs1_data, o_rs2_data}), 64'd0);
      check_eq("rst_addrs", 64'({o_rf_reg_addr, o_rf_dest_addr, o_rf_dest_data}), 64'd0);
      i_rst_n = 1'b1;
      tick();

      // Both operands x0
      base = rd_en_rises;
      do_read(5'd0, 5'd0, lat, d1, d2);
      check_eq("zero_latency", 64'(lat), 64'd3);
      check_eq("zero_data", 64'({d1, d2}), 64'd0);
      check_eq("zero_no_read", 64'(rd_en_rises - base), 64'd0);

      // rs1=5, rs2=7 via two RF reads
      base = rd_en_rises;
      do_read(5'd5, 5'd7, lat, d1, d2);
      check_eq("rd_rs1", 64'(d1), 64'h11);
      check_eq("rd_rs2", 64'(d2), 64'h22);
      check_eq("rd_latency", 64'(lat), 64'd9);
      check_eq("rd_two_reads", 64'(rd_en_rises - base), 64'd2);
      check_eq("rd_last_addr", 64'(o_rf_reg_addr), 64'd7);

      // Write x5=0xABCD in flight, then read rs1=5
      i_wb_addr = 5'd5;
      i_wb_data = 32'h0000_ABCD;
      i_wb_valid = 1'b1;
      check_eq("wb_ready_idle", 64'(o_wb_ready), 64'd1);
      tick();
      i_wb_valid = 1'b0;
      check_eq("wb_busy_ready", 64'(o_wb_ready), 64'd0);
      check_eq("wb_wr_en", 64'(o_rf_wr_en), 64'd1);
      check_eq("wb_dest_addr", 64'(o_rf_dest_addr), 64'd5);
      check_eq("wb_dest_data", 64'(o_rf_dest_data), 64'hABCD);
      base = rd_en_rises;
      do_read(5'd5, 5'd0, lat, d1, d2);
      check_eq("haz_rs1", 64'(d1), 64'hABCD);
      check_eq("haz_rs2", 64'(d2), 64'd0);
`ifdef RF_BYPASS_EN
      check_eq("haz_reads", 64'(rd_en_rises - base), 64'd0);
`else
      check_eq("haz_reads", 64'(rd_en_rises - base), 64'd1);
`endif
      check_eq("haz_overlap", 64'(overlap_cnt), 64'd0);
      for (int i = 0; i < 8 && o_rf_wr_en; i++) tick();

      // Writeback to x0 is dropped
      base = wr_en_rises;
      i_wb_addr = 5'd0;
      i_wb_data = 32'h0000_FFFF;
      i_wb_valid = 1'b1;
      tick();
      i_wb_valid = 1'b0;
      check_eq("x0_wb_ready", 64'(o_wb_ready), 64'd1);
      check_eq("x0_wr_en", 64'(o_rf_wr_en), 64'd0);
      tick(); tick(); tick();
      check_eq("x0_no_write", 64'(wr_en_rises - base), 64'd0);
      check_eq("x0_wb_ready_later", 64'(o_wb_ready), 64'd1);

      // RF never answers: read timeout
      rd_resp_on = 1'b0;
      check_eq("to_flag_before", 64'(o_timeout), 64'd0);
      base = rd_en_cycles;
      do_read(5'd9, 5'd0, lat, d1, d2);
      check_eq("to_latency", 64'(lat), 64'd19);
      check_eq("to_data", 64'({d1, d2}), 64'd0);
      check_eq("to_en_cycles", 64'(rd_en_cycles - base), 64'd16);
      check_eq("to_flag", 64'(o_timeout), 64'd1);
      check_eq("to_rd_en_low", 64'(o_rf_rd_en), 64'd0);

      // Reset while waiting on a read
      i_rs1_addr = 5'd3;
      i_rs2_addr = 5'd4;
      i_req_valid = 1'b1;
      tick();
      i_req_valid = 1'b0;
      tick(); tick();
      check_eq("mid_rd_en", 64'(o_rf_rd_en), 64'd1);
      base = op_valid_cnt;
      #2;
      i_rst_n = 1'b0;
      #1;
      check_eq("mid_rst_rd_en", 64'(o_rf_rd_en), 64'd0);
      check_eq("mid_rst_req_ready", 64'(o_req_ready), 64'd1);
      check_eq("mid_rst_timeout", 64'(o_timeout), 64'd0);
      tick(); tick();
      i_rst_n = 1'b1;
      last_rs1 = '0;
      rd_resp_on = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check_eq("mid_rst_no_op_valid", 64'(op_valid_cnt - base), 64'd0);
      check_eq("mid_rst_idle", 64'(o_req_ready), 64'd1);

      // Recovery after reset; x5 now holds the written value
      do_read(5'd7, 5'd5, lat, d1, d2);
      check_eq("post_rs1", 64'(d1), 64'h22);
      check_eq("post_rs2", 64'(d2), 64'hABCD);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected completion before 200000");
      $fatal(1);
   end
endmodule
